// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) shown in IF/ID during bubbles.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Source-register field positions in the instruction word.
    localparam int unsigned REG_W   = 5;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
interface fetch_stage_if #(
    parameter int unsigned PC_W = 32
);
    logic            ifetch_req;
    logic [PC_W-1:0] ifetch_addr;
    logic            ifetch_ack;
    logic [31:0]     ifetch_data;

    modport master (
        output ifetch_req,
        output ifetch_addr,
        input  ifetch_ack,
        input  ifetch_data
    );

    modport slave (
        input  ifetch_req,
        input  ifetch_addr,
        output ifetch_ack,
        output ifetch_data
    );
endinterface

// File: rtl/fetch_stage_skid.sv
// One-entry skid buffer catching a fetched word while IF/ID is stalled.
module fetch_stage_skid
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic [31:0]     data_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            full,
    output logic [31:0]     data_out,
    output logic [PC_W-1:0] pc_out
);
    logic            full_d, full_q;
    logic [31:0]     data_d, data_q;
    logic [PC_W-1:0] pc_d, pc_q;

    // Next-state: load captures a word, drain (or flush) empties the entry.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (load) begin
            full_d = 1'b1;
            data_d = data_in;
            pc_d   = pc_in;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= NOP_INSTR;
            pc_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign full     = full_q;
    assign data_out = data_q;
    assign pc_out   = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory handshake FSM and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              FETCH_stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    fetch_stage_if.master     ifetch,
    output logic              FETCH_valid,
    output logic [31:0]       FETCH_instr,
    output logic [PC_W-1:0]   FETCH_pc,
    output logic [REG_W-1:0]  FETCH_rs1,
    output logic [REG_W-1:0]  FETCH_rs2
);
    fetch_state_e    state_d, state_q;
    logic [PC_W-1:0] pc_d, pc_q;
    logic            req_d, req_q;
    logic [PC_W-1:0] addr_d, addr_q;
    logic            valid_d, valid_q;
    logic [31:0]     instr_d, instr_q;
    logic [PC_W-1:0] fpc_d, fpc_q;

    logic            ack_ok;
    logic            skid_load, skid_drain, skid_full, skid_full_next;
    logic [31:0]     skid_data;
    logic [PC_W-1:0] skid_pc;

    fetch_stage_skid #(
        .PC_W (PC_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .drain    (skid_drain),
        .data_in  (ifetch.ifetch_data),
        .pc_in    (pc_q),
        .full     (skid_full),
        .data_out (skid_data),
        .pc_out   (skid_pc)
    );

    // Next-state for FSM, pc, IF/ID and the registered request outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        fpc_d      = fpc_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        ack_ok     = req_q && ifetch.ifetch_ack;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (ack_ok && !redirect) pc_d = pc_q + PC_W'(4);
            ST_DROP: if (ack_ok) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase

        if (redirect) begin
            pc_d       = redirect_pc & ~PC_W'(3);
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            skid_drain = 1'b1;
            // A request still in flight must be waited out before refetching.
            state_d    = (req_q && !ifetch.ifetch_ack) ? ST_DROP : ST_REQ;
        end else if (skid_full && !FETCH_stall) begin
            valid_d    = 1'b1;
            instr_d    = skid_data;
            fpc_d      = skid_pc;
            skid_drain = 1'b1;
        end else if (state_q == ST_REQ && ack_ok) begin
            if (!FETCH_stall || !valid_q) begin
                valid_d = 1'b1;
                instr_d = ifetch.ifetch_data;
                fpc_d   = pc_q;
            end else begin
                skid_load = 1'b1;
            end
        end else if (!FETCH_stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        // Request outputs are registered, so derive them from next-cycle state.
        // A full skid can only arise on an ack, so req never drops mid-handshake.
        skid_full_next = skid_load || (skid_full && !skid_drain);
        req_d  = (state_d == ST_DROP) || (state_d == ST_REQ && !skid_full_next);
        addr_d = (state_d == ST_DROP) ? addr_q : pc_d;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VEC;
            req_q   <= 1'b0;
            addr_q  <= RESET_VEC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
        end
    end

    assign ifetch.ifetch_req  = req_q;
    assign ifetch.ifetch_addr = addr_q;
    assign FETCH_valid        = valid_q;
    assign FETCH_instr        = instr_q;
    assign FETCH_pc           = fpc_q;
    assign FETCH_rs1          = instr_q[RS1_LSB +: REG_W];
    assign FETCH_rs2          = instr_q[RS2_LSB +: REG_W];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a latency-programmable memory responder.
module tb_fetch_stage;
    logic        clk;
    logic        rst_n;
    logic        FETCH_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        FETCH_valid;
    logic [31:0] FETCH_instr;
    logic [31:0] FETCH_pc;
    logic [4:0]  FETCH_rs1;
    logic [4:0]  FETCH_rs2;

    int checks = 0;
    int errors = 0;

    // Memory responder: ack arrives lat cycles after req first rises; data = {addr[15:0], addr[15:0]}.
    int unsigned lat;
    int unsigned wcnt;
    logic        ack_force;

    fetch_stage_if #(.PC_W(32)) bus ();

    assign bus.ifetch_ack  = ack_force || (bus.ifetch_req && (wcnt == lat));
    assign bus.ifetch_data = {bus.ifetch_addr[15:0], bus.ifetch_addr[15:0]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            wcnt <= 0;
        else if (bus.ifetch_req && bus.ifetch_ack) wcnt <= 0;
        else if (bus.ifetch_req)               wcnt <= wcnt + 1;
        else                                   wcnt <= 0;
    end

    fetch_stage #(
        .PC_W      (32),
        .RESET_VEC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .FETCH_stall (FETCH_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifetch      (bus),
        .FETCH_valid (FETCH_valid),
        .FETCH_instr (FETCH_instr),
        .FETCH_pc    (FETCH_pc),
        .FETCH_rs1   (FETCH_rs1),
        .FETCH_rs2   (FETCH_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; FETCH_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        lat = 0; ack_force = 1'b0;
        tick(); tick();
        checks++; if (bus.ifetch_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", bus.ifetch_req); end
        checks++; if (bus.ifetch_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", bus.ifetch_addr); end
        checks++; if (FETCH_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", FETCH_valid); end
        checks++; if (FETCH_instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", FETCH_instr); end
        checks++; if (FETCH_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", FETCH_pc); end
        rst_n = 1'b1;
        tick(); // IDLE cycle consumed
    endtask

    task automatic test_back_to_back();
        // First REQ cycle
        checks++; if (bus.ifetch_req !== 1'b1 || bus.ifetch_addr !== 32'h100) begin errors++; $display("FAIL b2b_first_req: got req=%0b addr=%h expected req=1 addr=00000100", bus.ifetch_req, bus.ifetch_addr); end
        checks++; if (FETCH_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_early: got %0b expected 0", FETCH_valid); end
        tick();
        checks++; if (bus.ifetch_addr !== 32'h104) begin errors++; $display("FAIL b2b_addr1: got %h expected 00000104", bus.ifetch_addr); end
        checks++; if (FETCH_valid !== 1'b1 || FETCH_instr !== 32'h0100_0100 || FETCH_pc !== 32'h100) begin errors++; $display("FAIL b2b_ifid0: got v=%0b i=%h pc=%h expected v=1 i=01000100 pc=00000100", FETCH_valid, FETCH_instr, FETCH_pc); end
        tick();
        checks++; if (bus.ifetch_addr !== 32'h108) begin errors++; $display("FAIL b2b_addr2: got %h expected 00000108", bus.ifetch_addr); end
        checks++; if (FETCH_instr !== 32'h0104_0104 || FETCH_pc !== 32'h104) begin errors++; $display("FAIL b2b_ifid1: got i=%h pc=%h expected i=01040104 pc=00000104", FETCH_instr, FETCH_pc); end
        checks++; if (FETCH_rs1 !== 5'd8 || FETCH_rs2 !== 5'd16) begin errors++; $display("FAIL b2b_rs: got rs1=%0d rs2=%0d expected rs1=8 rs2=16", FETCH_rs1, FETCH_rs2); end
    endtask

    task automatic test_stall();
        FETCH_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (FETCH_instr !== 32'h0104_0104 || FETCH_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got v=%0b i=%h expected v=1 i=01040104", i, FETCH_valid, FETCH_instr); end
            checks++; if (bus.ifetch_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %0b expected 0", i, bus.ifetch_req); end
        end
        FETCH_stall = 1'b0;
        tick();
        checks++; if (FETCH_instr !== 32'h0108_0108 || FETCH_pc !== 32'h108) begin errors++; $display("FAIL stall_drain: got i=%h pc=%h expected i=01080108 pc=00000108", FETCH_instr, FETCH_pc); end
        checks++; if (bus.ifetch_req !== 1'b1 || bus.ifetch_addr !== 32'h10C) begin errors++; $display("FAIL stall_rereq: got req=%0b addr=%h expected req=1 addr=0000010c", bus.ifetch_req, bus.ifetch_addr); end
        tick();
        checks++; if (FETCH_instr !== 32'h010C_010C || FETCH_pc !== 32'h10C) begin errors++; $display("FAIL stall_next: got i=%h pc=%h expected i=010c010c pc=0000010c", FETCH_instr, FETCH_pc); end
    endtask

    task automatic test_redirect_drop();
        lat = 2;
        tick(); // wait cycle for 0x110
        checks++; if (FETCH_valid !== 1'b0 || bus.ifetch_addr !== 32'h110) begin errors++; $display("FAIL drop_wait: got v=%0b addr=%h expected v=0 addr=00000110", FETCH_valid, bus.ifetch_addr); end
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        checks++; if (bus.ifetch_req !== 1'b1 || bus.ifetch_addr !== 32'h110) begin errors++; $display("FAIL drop_stable: got req=%0b addr=%h expected req=1 addr=00000110", bus.ifetch_req, bus.ifetch_addr); end
        checks++; if (FETCH_valid !== 1'b0 || FETCH_instr !== 32'h13) begin errors++; $display("FAIL drop_bubble: got v=%0b i=%h expected v=0 i=00000013", FETCH_valid, FETCH_instr); end
        tick();
        checks++; if (bus.ifetch_req !== 1'b1 || bus.ifetch_addr !== 32'h200) begin errors++; $display("FAIL drop_newaddr: got req=%0b addr=%h expected req=1 addr=00000200", bus.ifetch_req, bus.ifetch_addr); end
        checks++; if (FETCH_valid !== 1'b0) begin errors++; $display("FAIL drop_discard: got v=%0b i=%h expected v=0", FETCH_valid, FETCH_instr); end
        tick(); tick();
        checks++; if (FETCH_valid !== 1'b0 || bus.ifetch_addr !== 32'h200) begin errors++; $display("FAIL drop_wait2: got v=%0b addr=%h expected v=0 addr=00000200", FETCH_valid, bus.ifetch_addr); end
        tick();
        checks++; if (FETCH_valid !== 1'b1 || FETCH_instr !== 32'h0200_0200 || FETCH_pc !== 32'h200) begin errors++; $display("FAIL drop_fetch: got v=%0b i=%h pc=%h expected v=1 i=02000200 pc=00000200", FETCH_valid, FETCH_instr, FETCH_pc); end
    endtask

    task automatic test_redirect_skid();
        lat = 0;
        FETCH_stall = 1'b1;
        tick(); // 0x204 lands in skid
        checks++; if (bus.ifetch_req !== 1'b0 || FETCH_instr !== 32'h0200_0200) begin errors++; $display("FAIL rskid_pre: got req=%0b i=%h expected req=0 i=02000200", bus.ifetch_req, FETCH_instr); end
        ack_force = 1'b1; redirect = 1'b1; redirect_pc = 32'h202;
        tick();
        ack_force = 1'b0; redirect = 1'b0; FETCH_stall = 1'b0;
        checks++; if (FETCH_valid !== 1'b0 || FETCH_instr !== 32'h13) begin errors++; $display("FAIL rskid_nop: got v=%0b i=%h expected v=0 i=00000013", FETCH_valid, FETCH_instr); end
        checks++; if (bus.ifetch_req !== 1'b1 || bus.ifetch_addr !== 32'h200) begin errors++; $display("FAIL rskid_req: got req=%0b addr=%h expected req=1 addr=00000200", bus.ifetch_req, bus.ifetch_addr); end
        tick();
        checks++; if (FETCH_instr !== 32'h0200_0200 || FETCH_pc !== 32'h200) begin errors++; $display("FAIL rskid_fetch: got i=%h pc=%h expected i=02000200 pc=00000200", FETCH_instr, FETCH_pc); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (bus.ifetch_addr !== 32'hFFFF_FFFC || FETCH_valid !== 1'b0) begin errors++; $display("FAIL wrap_addr: got addr=%h v=%0b expected addr=fffffffc v=0", bus.ifetch_addr, FETCH_valid); end
        tick();
        checks++; if (bus.ifetch_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected 00000000", bus.ifetch_addr); end
        checks++; if (FETCH_instr !== 32'hFFFC_FFFC || FETCH_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ifid: got i=%h pc=%h expected i=fffcfffc pc=fffffffc", FETCH_instr, FETCH_pc); end
    endtask

    task automatic test_reset_midflight();
        lat = 2;
        tick();
        checks++; if (bus.ifetch_req !== 1'b1 || bus.ifetch_ack !== 1'b0) begin errors++; $display("FAIL rmid_pending: got req=%0b ack=%0b expected req=1 ack=0", bus.ifetch_req, bus.ifetch_ack); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ifetch_req !== 1'b0 || FETCH_valid !== 1'b0 || bus.ifetch_addr !== 32'h100) begin errors++; $display("FAIL rmid_async: got req=%0b v=%0b addr=%h expected req=0 v=0 addr=00000100", bus.ifetch_req, FETCH_valid, bus.ifetch_addr); end
        lat = 0;
        tick();
        rst_n = 1'b1;
        tick(); // IDLE
        checks++; if (bus.ifetch_req !== 1'b1 || bus.ifetch_addr !== 32'h100) begin errors++; $display("FAIL rmid_restart: got req=%0b addr=%h expected req=1 addr=00000100", bus.ifetch_req, bus.ifetch_addr); end
        tick();
        checks++; if (FETCH_valid !== 1'b1 || FETCH_instr !== 32'h0100_0100) begin errors++; $display("FAIL rmid_fetch: got v=%0b i=%h expected v=1 i=01000100", FETCH_valid, FETCH_instr); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_drop();
        test_redirect_skid();
        test_wrap();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
